// File: rtl/burst_mem_responder_if.sv
// Cache burst (bfp_*) bus between a cache miss FSM (master) and the memory responder (slave).
interface burst_mem_responder_if;
    logic [31:0] bfp_addr;
    logic        bfp_read;
    logic        bfp_write;
    logic [63:0] bfp_wdata;
    logic        bfp_ready;
    logic [31:0] bfp_raddr;
    logic [63:0] bfp_rdata;
    logic        bfp_rvalid;

    modport master (
        output bfp_addr,
        output bfp_read,
        output bfp_write,
        output bfp_wdata,
        input  bfp_ready,
        input  bfp_raddr,
        input  bfp_rdata,
        input  bfp_rvalid
    );

    modport slave (
        input  bfp_addr,
        input  bfp_read,
        input  bfp_write,
        input  bfp_wdata,
        output bfp_ready,
        output bfp_raddr,
        output bfp_rdata,
        output bfp_rvalid
    );
endinterface

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the cache burst bus: 4-beat line writebacks, queued line reads
// returned as 4 ordered 64-bit beats after a fixed latency, backed by an internal line array.
module burst_mem_responder #(
    parameter int unsigned DEPTH_LINES  = 64,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned QDEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    burst_mem_responder_if.slave  bfp,
    output logic                  proto_err
);

    localparam int unsigned IdxW = $clog2(DEPTH_LINES);
    localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CntW = $clog2(QDEPTH + 1);
    localparam int unsigned LatW = $clog2(READ_LATENCY + 1);
    // Two cycles are spent in the Idle->Wait hop and the Wait->Burst edge itself.
    localparam logic [LatW-1:0] LatLoad = LatW'(READ_LATENCY - 2);

    typedef enum logic [1:0] {RIdle, RWait, RBurst} rstate_e;

    // Line array and request FIFO storage, deliberately not reset
    logic [3:0][63:0] mem_q       [DEPTH_LINES];
    logic [26:0]      fifo_line_q [QDEPTH];

    // Write side and FIFO control
    logic [1:0]      wr_cnt_q;
    logic [26:0]     wr_line_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] fifo_count_q;
    logic            proto_err_q;

    // Return FSM
    rstate_e         state_q;
    logic [LatW-1:0] lat_cnt_q;
    logic [1:0]      beat_q;
    logic            rvalid_q;
    logic [31:0]     raddr_q;
    logic [63:0]     rdata_q;

    logic            ready;
    logic            wr_accept;
    logic            rd_attempt;
    logic            rd_accept;
    logic            rd_drop;
    logic            addr_err;
    logic            pop;
    logic            fifo_nonempty_after_pop;
    logic [26:0]     req_line;
    logic [26:0]     wr_line;
    logic [IdxW-1:0] wr_idx;
    logic [26:0]     head_line;
    logic [IdxW-1:0] head_idx;
    logic [1:0]      rd_beat;
    logic [63:0]     rd_word;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^bfp.bfp_addr[4:0];

    assign req_line = bfp.bfp_addr[31:5];
    assign ready    = !rst && ((fifo_count_q < CntW'(QDEPTH)) || (wr_cnt_q != 2'd0));

    assign wr_accept  = bfp.bfp_write && ready;
    assign rd_attempt = bfp.bfp_read && ready;
    assign rd_accept  = rd_attempt && !bfp.bfp_write && (wr_cnt_q == 2'd0);
    assign rd_drop    = rd_attempt && !rd_accept;

    // Beats 1-3 always land in the line latched by beat 0
    assign wr_line  = (wr_cnt_q == 2'd0) ? req_line : wr_line_q;
    assign wr_idx   = wr_line[IdxW-1:0];
    assign addr_err = wr_accept && (wr_cnt_q != 2'd0) && (req_line != wr_line_q);

    assign head_line = fifo_line_q[rd_ptr_q];
    assign head_idx  = head_line[IdxW-1:0];

    assign pop = (state_q == RBurst) && (beat_q == 2'd3);
    assign fifo_nonempty_after_pop = (fifo_count_q != CntW'(1)) || rd_accept;

    // Word the FSM will present next; a write to that word on the same edge is forwarded.
    always_comb begin
        rd_beat = (state_q == RBurst) ? beat_q + 2'd1 : 2'd0;
        rd_word = mem_q[head_idx][rd_beat];
        if (wr_accept && (wr_idx == head_idx) && (wr_cnt_q == rd_beat)) begin
            rd_word = bfp.bfp_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_idx][wr_cnt_q] <= bfp.bfp_wdata;
        end
        if (rd_accept) begin
            fifo_line_q[wr_ptr_q] <= req_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q     <= 2'd0;
            wr_line_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_cnt_q <= wr_cnt_q + 2'd1;
                if (wr_cnt_q == 2'd0) begin
                    wr_line_q <= req_line;
                end
            end
            if (rd_accept) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({rd_accept, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CntW'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CntW'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
            if (rd_drop || addr_err) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RIdle;
            lat_cnt_q <= '0;
            beat_q    <= 2'd0;
            rvalid_q  <= 1'b0;
            raddr_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                RIdle: begin
                    if (fifo_count_q != '0) begin
                        state_q   <= RWait;
                        lat_cnt_q <= LatLoad;
                    end
                end
                RWait: begin
                    if (lat_cnt_q == '0) begin
                        state_q  <= RBurst;
                        beat_q   <= 2'd0;
                        rvalid_q <= 1'b1;
                        raddr_q  <= {head_line, 5'b0};
                        rdata_q  <= rd_word;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LatW'(1);
                    end
                end
                RBurst: begin
                    if (beat_q == 2'd3) begin
                        rvalid_q <= 1'b0;
                        raddr_q  <= '0;
                        rdata_q  <= '0;
                        if (fifo_nonempty_after_pop) begin
                            state_q   <= RWait;
                            lat_cnt_q <= LatLoad;
                        end else begin
                            state_q <= RIdle;
                        end
                    end else begin
                        beat_q  <= rd_beat;
                        rdata_q <= rd_word;
                    end
                end
                default: state_q <= RIdle;
            endcase
        end
    end

    assign bfp.bfp_ready  = ready;
    assign bfp.bfp_rvalid = rvalid_q;
    assign bfp.bfp_raddr  = raddr_q;
    assign bfp.bfp_rdata  = rdata_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: writeback/read, queue full, protocol errors,
// reset during return and address aliasing.
module tb_burst_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic proto_err;
    int   total = 0;
    int   bad   = 0;

    burst_mem_responder_if bus();

    burst_mem_responder #(
        .DEPTH_LINES (64),
        .READ_LATENCY(4),
        .QDEPTH      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bfp      (bus),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] pat_line(input logic [31:0] line);
        logic [255:0] v;
        for (int j = 0; j < 4; j++) v[j*64 +: 64] = {16'hA5A5, line[15:0], 16'h5A5A, 16'(j)};
        return v;
    endfunction

    task automatic write_beat(input logic [31:0] addr, input logic [63:0] data);
        total++;
        if (bus.bfp_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_ready: got %b want 1", bus.bfp_ready);
        end
        bus.bfp_addr  = addr;
        bus.bfp_wdata = data;
        bus.bfp_write = 1'b1;
        tick();
        bus.bfp_write = 1'b0;
    endtask

    task automatic write_line(input logic [31:0] addr, input logic [255:0] data);
        for (int j = 0; j < 4; j++) write_beat(addr, data[j*64 +: 64]);
    endtask

    // Issue a read into an idle responder and check the 4-beat return at accept+4..+7.
    task automatic read_check(input logic [31:0] addr, input logic [255:0] exp, input string nm);
        logic [31:0] exp_raddr;
        logic        exp_v;
        exp_raddr = addr & 32'hFFFF_FFE0;
        total++;
        if (bus.bfp_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s read_ready: got %b want 1", nm, bus.bfp_ready);
        end
        bus.bfp_addr = addr;
        bus.bfp_read = 1'b1;
        tick();
        bus.bfp_read = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_v = (k >= 4 && k <= 7);
            total++;
            if (bus.bfp_rvalid !== exp_v) begin
                bad++;
                $display("FAIL %s rvalid k=%0d: got %b want %b", nm, k, bus.bfp_rvalid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (bus.bfp_raddr !== exp_raddr) begin
                    bad++;
                    $display("FAIL %s raddr k=%0d: got %h want %h", nm, k, bus.bfp_raddr,
                             exp_raddr);
                end
                total++;
                if (bus.bfp_rdata !== exp[(k-4)*64 +: 64]) begin
                    bad++;
                    $display("FAIL %s rdata k=%0d: got %h want %h", nm, k, bus.bfp_rdata,
                             exp[(k-4)*64 +: 64]);
                end
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (bus.bfp_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b want 0", bus.bfp_ready);
        end
        total++;
        if (bus.bfp_rvalid !== 1'b0) begin
            bad++; $display("FAIL reset_rvalid: got %b want 0", bus.bfp_rvalid);
        end
        total++;
        if (proto_err !== 1'b0) begin
            bad++; $display("FAIL reset_proto_err: got %b want 0", proto_err);
        end
        total++;
        if (bus.bfp_rdata !== 64'd0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", bus.bfp_rdata);
        end
        total++;
        if (bus.bfp_raddr !== 32'd0) begin
            bad++; $display("FAIL reset_raddr: got %h want 0", bus.bfp_raddr);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.bfp_ready !== 1'b1) begin
            bad++; $display("FAIL release_ready: got %b want 1", bus.bfp_ready);
        end
        tick();
    endtask

    task automatic test_writeback_read();
        write_beat(32'h0000_0040, 64'h1111_1111_1111_1111);
        write_beat(32'h0000_0040, 64'h2222_2222_2222_2222);
        write_beat(32'h0000_0040, 64'h3333_3333_3333_3333);
        write_beat(32'h0000_0040, 64'h4444_4444_4444_4444);
        read_check(32'h0000_0044, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, "wb_read");
        total++;
        if (proto_err !== 1'b0) begin
            bad++; $display("FAIL wb_proto_err: got %b want 0", proto_err);
        end
    endtask

    task automatic test_queue_full();
        logic [31:0]  lines [5];
        int           beat_k [$];
        logic [31:0]  beat_a [$];
        logic [63:0]  beat_d [$];
        logic [255:0] exp_line;
        int           first_ready = -1;
        logic         pending;
        logic         accept_now;
        int           exp_k;
        lines = '{32'h00, 32'h20, 32'h40, 32'h60, 32'h20};
        for (int i = 0; i < 4; i++) write_line(lines[i], pat_line(lines[i]));
        bus.bfp_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.bfp_addr = lines[i];
            tick();
        end
        total++;
        if (bus.bfp_ready !== 1'b0) begin
            bad++; $display("FAIL qfull_ready: got %b want 0", bus.bfp_ready);
        end
        bus.bfp_addr = lines[4];
        pending = 1'b1;
        for (int k = 3; k < 40; k++) begin
            accept_now = pending && (bus.bfp_ready === 1'b1);
            if (accept_now && first_ready < 0) first_ready = k;
            tick();
            if (accept_now) begin
                bus.bfp_read = 1'b0;
                pending = 1'b0;
            end
            if (bus.bfp_rvalid === 1'b1) begin
                beat_k.push_back(k + 1);
                beat_a.push_back(bus.bfp_raddr);
                beat_d.push_back(bus.bfp_rdata);
            end
        end
        bus.bfp_read = 1'b0;
        total++;
        if (first_ready !== 8) begin
            bad++; $display("FAIL qfull_first_ready: got %0d want 8", first_ready);
        end
        total++;
        if (beat_k.size() !== 20) begin
            bad++; $display("FAIL qfull_beats: got %0d want 20", beat_k.size());
        end
        for (int i = 0; i < beat_k.size() && i < 20; i++) begin
            exp_k    = 4 + 7 * (i / 4) + (i % 4);
            exp_line = pat_line(lines[i/4]);
            total++;
            if (beat_k[i] !== exp_k || beat_a[i] !== lines[i/4] ||
                beat_d[i] !== exp_line[(i%4)*64 +: 64]) begin
                bad++;
                $display("FAIL qfull_beat%0d: got k=%0d a=%h d=%h want k=%0d a=%h d=%h", i,
                         beat_k[i], beat_a[i], beat_d[i], exp_k, lines[i/4],
                         exp_line[(i%4)*64 +: 64]);
            end
        end
    endtask

    task automatic test_read_during_wb();
        logic [255:0] d;
        int           seen = 0;
        d = pat_line(32'h100);
        total++;
        if (proto_err !== 1'b0) begin
            bad++; $display("FAIL rdwb_pre_proto: got %b want 0", proto_err);
        end
        write_beat(32'h100, d[63:0]);
        write_beat(32'h100, d[127:64]);
        total++;
        if (bus.bfp_ready !== 1'b1) begin
            bad++; $display("FAIL rdwb_ready: got %b want 1", bus.bfp_ready);
        end
        bus.bfp_addr = 32'h100;
        bus.bfp_read = 1'b1;
        tick();
        bus.bfp_read = 1'b0;
        total++;
        if (proto_err !== 1'b1) begin
            bad++; $display("FAIL rdwb_proto_err: got %b want 1", proto_err);
        end
        write_beat(32'h100, d[191:128]);
        write_beat(32'h100, d[255:192]);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.bfp_rvalid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rdwb_no_return: got %0d beats want 0", seen);
        end
        total++;
        if (proto_err !== 1'b1) begin
            bad++; $display("FAIL rdwb_sticky: got %b want 1", proto_err);
        end
        read_check(32'h100, d, "rdwb_line");
    endtask

    task automatic test_addr_change();
        logic [255:0] b;
        b = pat_line(32'h80);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (proto_err !== 1'b0) begin
            bad++; $display("FAIL addr_chg_clear: got %b want 0", proto_err);
        end
        write_line(32'hA0, pat_line(32'hA0));
        write_beat(32'h80, b[63:0]);
        write_beat(32'hA0, b[127:64]);
        total++;
        if (proto_err !== 1'b1) begin
            bad++; $display("FAIL addr_chg_proto_err: got %b want 1", proto_err);
        end
        write_beat(32'h80, b[191:128]);
        write_beat(32'h80, b[255:192]);
        read_check(32'h80, b, "addr_chg_80");
        read_check(32'hA0, pat_line(32'hA0), "addr_chg_a0");
    endtask

    task automatic test_reset_mid_return();
        logic [255:0] b;
        int           seen = 0;
        b = pat_line(32'h80);
        bus.bfp_addr = 32'h80;
        bus.bfp_read = 1'b1;
        tick();
        bus.bfp_read = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        total++;
        if (bus.bfp_rvalid !== 1'b1 || bus.bfp_rdata !== b[127:64]) begin
            bad++;
            $display("FAIL rmr_beat1: got v=%b d=%h want v=1 d=%h", bus.bfp_rvalid,
                     bus.bfp_rdata, b[127:64]);
        end
        rst = 1'b1;
        tick();
        total++;
        if (bus.bfp_rvalid !== 1'b0) begin
            bad++; $display("FAIL rmr_rvalid: got %b want 0", bus.bfp_rvalid);
        end
        total++;
        if (bus.bfp_ready !== 1'b0 || bus.bfp_rdata !== 64'd0 || bus.bfp_raddr !== 32'd0) begin
            bad++;
            $display("FAIL rmr_outputs: got rdy=%b d=%h a=%h want 0", bus.bfp_ready,
                     bus.bfp_rdata, bus.bfp_raddr);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.bfp_ready !== 1'b1) begin
            bad++; $display("FAIL rmr_ready: got %b want 1", bus.bfp_ready);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.bfp_rvalid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rmr_fifo_empty: got %0d beats want 0", seen);
        end
        read_check(32'h80, b, "rmr_reread");
    endtask

    task automatic test_alias();
        write_line(32'h0000_0800, pat_line(32'h800));
        read_check(32'h0000_0000, pat_line(32'h800), "alias");
    endtask

    initial begin
        bus.bfp_addr  = '0;
        bus.bfp_read  = 1'b0;
        bus.bfp_write = 1'b0;
        bus.bfp_wdata = '0;
        test_reset();
        test_writeback_read();
        test_queue_full();
        test_read_during_wb();
        test_addr_change();
        test_reset_mid_return();
        test_alias();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
